uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART_transmitter between N_REQ byte producers. Round-robin picks one
//  pending requester, latches its byte, drives start/data_in for exactly one frame,
//  and self-times the frame (the transmitter exposes no busy). Sits beside
//  UART_transmitter in the top level; its start/data_in feed the transmitter directly.
// PARAMETERS
//  N_REQ        4    number of requesters (>=2)
//  CLKS_PER_BIT 434  clk cycles per baud bit; must equal the datapath's baud divider
//  START_HOLD   434  cycles start is held high (>= CLKS_PER_BIT so a baud tick sees it)
//  GAP_BITS     1    idle bit-times inserted after each frame (UART_ARB_GAP_EN only)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous reset, active-low
//  req_valid  in   N_REQ      requester i has a byte; held until req_ready[i]
//  req_data   in   8*N_REQ    byte of requester i at [8*i +: 8]
//  req_ready  out  N_REQ      one-hot accept pulse, one cycle
//  grant_id   out  $clog2(N_REQ)  index of requester owning the current frame
//  busy       out  1          high from acceptance until return to IDLE
//  start      out  1          to UART_transmitter.start
//  data_in    out  8          to UART_transmitter.data_in, stable for whole frame
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; start=0, data_in=0, busy=0, grant_id=0,
//    req_ready=0, rr pointer=N_REQ-1 (requester 0 wins first), all counters 0.
//  - FRAME_CYCLES = 10*CLKS_PER_BIT (start + 8 data + stop), localparam.
//  - States: IDLE -> LOAD -> WAIT -> [GAP] -> IDLE.
//  - IDLE: if |req_valid, winner = first set bit searching from ptr+1 (wrap mod N_REQ).
//    Same cycle: req_ready[winner]=1 (combinational, only in IDLE). Next edge: data_in
//    <= req_data[winner], grant_id<=winner, ptr<=winner, busy<=1, cnt<=0, -> LOAD.
//  - LOAD: start=1; cnt increments; after START_HOLD cycles -> WAIT, start=0.
//  - WAIT: cnt continues from LOAD (not cleared); when cnt==FRAME_CYCLES-1 -> IDLE
//    (or GAP). Total occupancy from LOAD entry = FRAME_CYCLES cycles exactly.
//  - Accept-to-accept minimum spacing: FRAME_CYCLES+1 cycles (no gap).
//  - Requests arriving while busy wait; req_ready never asserts outside IDLE.
//  - Single requester continuously valid: served back-to-back, no starvation of others:
//    any waiting requester is granted within N_REQ frames.
//  - req_valid dropped before grant: legal, simply not considered.
//  - data_in/grant_id hold last value in IDLE; they change only on acceptance.
//  - Counter width $clog2(FRAME_CYCLES + GAP_BITS*CLKS_PER_BIT + 1); never wraps.
//  - Reset mid-frame: immediate return to reset values; the shared rst also resets the
//    transmitter, so no partial frame is resumed; accepted byte is discarded.
//  - START_HOLD >= FRAME_CYCLES is illegal (elaboration assertion).
// CONFIGURATION
//  UART_ARB_GAP_EN defined: after WAIT, enter GAP for GAP_BITS*CLKS_PER_BIT cycles,
//    start=0, busy=1, then IDLE. Guarantees idle-high line time between frames.
//  Not defined: GAP state absent, WAIT goes straight to IDLE; GAP_BITS ignored.
// STRUCTURE
//  uart_arb_pkg: typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} arb_state_t;
//    localparam DATA_W = 8; localparam FRAME_BITS = 10.
//  Sub-module uart_rr_picker (combinational): inputs req, ptr; outputs one-hot grant,
//    grant index, any. Instantiated once; everything else in this module.
// TESTING (CLKS_PER_BIT=4, START_HOLD=4, N_REQ=4, FRAME_CYCLES=40)
//  1 Reset: rst low mid-LOAD with req_valid=4'b1111 -> start=0, busy=0, req_ready=0
//    asynchronously; after release requester 0 granted first.
//  2 Single: req_valid=4'b0100, data 8'hA5 -> req_ready=4'b0100 one cycle, data_in=A5,
//    start high 4 cycles, busy high 40 cycles, tx decodes 0xA5 with 1 stop bit.
//  3 Round-robin: all valid continuously, bytes 11/22/33/44 -> grant order 0,1,2,3,0;
//    accepts spaced exactly 41 cycles.
//  4 Late request: req 1 valid during req 0 frame -> no req_ready until IDLE, then req 1
//    accepted first IDLE cycle; data_in unchanged until then.
//  5 Withdrawal: req 3 valid 5 cycles in WAIT then dropped -> never granted, no ready.
//  6 UART_ARB_GAP_EN, GAP_BITS=1: back-to-back frames spaced 45 cycles; tx high in gap.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The optional inter-frame gap is enabled with the UART_ARB_GAP_EN macro.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        GAP
    } arb_state_t;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 10;

    // Start bit + 8 data bits + stop bit, in clk cycles.
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1,
// wrapping modulo N_REQ.
module uart_rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers; it
// self-times each frame. Define UART_ARB_GAP_EN to add GAP_BITS idle bit-times per frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned START_HOLD   = 434,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      start,
    output logic [DATA_W-1:0]         data_in
);

    localparam int unsigned IDX_W        = $clog2(N_REQ);
    localparam int unsigned FRAME_CYCLES = frame_cycles(CLKS_PER_BIT);
    localparam int unsigned GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
`ifdef UART_ARB_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(FRAME_CYCLES + GAP_CYCLES - 1);
`endif

    if (N_REQ < 2) begin : gen_bad_nreq
        $error("uart_tx_arbiter: N_REQ must be at least 2");
    end
    if (START_HOLD < 1 || START_HOLD >= FRAME_CYCLES) begin : gen_bad_hold
        $error("uart_tx_arbiter: START_HOLD must be in [1, FRAME_CYCLES)");
    end
`ifdef UART_ARB_GAP_EN
    if (GAP_BITS < 1) begin : gen_bad_gap
        $error("uart_tx_arbiter: GAP_BITS must be at least 1 when the gap is enabled");
    end
`endif

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    uart_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        busy_d    = busy_q;
        req_ready = '0;
        start     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gate with rst so the accept pulse is also silent while reset is asserted.
                req_ready = pick_grant & {N_REQ{rst}};
                if (pick_any) begin
                    state_d = LOAD;
                    data_d  = req_data[pick_idx*DATA_W +: DATA_W];
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                start = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Count carries over from LOAD so occupancy is exactly FRAME_CYCLES.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FRAME_LAST) begin
`ifdef UART_ARB_GAP_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
`endif
                end
            end
            GAP: begin
`ifdef UART_ARB_GAP_EN
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
`else
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_id = grant_q;
    assign data_in  = data_q;
    assign busy     = busy_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
    a_start_busy:   assert property (@(posedge clk) disable iff (!rst) start |-> busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against an occupancy-countdown reference model.
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int CPB   = 4;
    localparam int HOLD  = 4;
`ifdef UART_ARB_GAP_EN
    localparam int TOTAL = 10 * CPB + CPB;
`else
    localparam int TOTAL = 10 * CPB;
`endif
    localparam int SPACING = TOTAL + 1;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 start;
    logic [7:0]           data_in;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .CLKS_PER_BIT (CPB),
        .START_HOLD   (HOLD),
        .GAP_BITS     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .start     (start),
        .data_in   (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame occupies TOTAL cycles after acceptance; while free, the
    // winner is the first valid requester after the previous winner.
    int          m_occ;
    int          m_last;
    logic [7:0]  m_data;
    int          m_grant;

    always @(negedge clk) begin
        int               w;
        int               pos;
        logic [N_REQ-1:0] exp_ready;
        if (!rst) begin
            m_occ   = 0;
            m_last  = N_REQ - 1;
            m_data  = 8'h00;
            m_grant = 0;
            check("rst_ready", 32'(req_ready), 32'(0));
            check("rst_busy",  32'(busy),      32'(0));
            check("rst_start", 32'(start),     32'(0));
        end else begin
            w         = -1;
            exp_ready = '0;
            if (m_occ == 0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    if (w < 0 && req_valid[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            pos = TOTAL - m_occ;
            check("ready",    32'(req_ready), 32'(exp_ready));
            check("busy",     32'(busy),      32'(m_occ != 0));
            check("start",    32'(start),     32'(m_occ != 0 && pos < HOLD));
            check("data_in",  32'(data_in),   32'(m_data));
            check("grant_id", 32'(grant_id),  32'(m_grant));
            if (m_occ > 0) begin
                m_occ--;
            end else if (w >= 0) begin
                m_occ   = TOTAL;
                m_last  = w;
                m_data  = req_data[8*w +: 8];
                m_grant = w;
            end
        end
    end

    // Producer-side helpers: one cycle per tick, inputs change 1 time unit after posedge.
    logic [N_REQ-1:0] seen;
    logic             seen_busy;
    logic             seen_start;
    logic             hold_all;
    int               cyc;
    int               acc_id;
    int               n_acc;

    task automatic tick();
        @(negedge clk);
        seen       = req_ready;
        seen_busy  = busy;
        seen_start = start;
        @(posedge clk);
        #1;
        cyc++;
        if (seen != '0) begin
            n_acc++;
            for (int i = 0; i < N_REQ; i++) if (seen[i]) acc_id = i;
        end
        if (!hold_all) req_valid = req_valid & ~seen;
    endtask

    task automatic wait_accept(output int id, output int at);
        id = -1;
        at = cyc;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (seen != '0) begin
                id = acc_id;
                at = cyc;
                break;
            end
        end
        check("accept_seen", 32'(seen != '0), 32'(1));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!seen_busy) break;
        end
        check("idle_reached", 32'(seen_busy), 32'(0));
    endtask

    initial begin
        int id;
        int at;
        int prev_at;
        int n_start;
        int n_busy;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        hold_all  = 1'b0;
        cyc       = 0;
        n_acc     = 0;
        acc_id    = 0;
        #3;
        check("por_grant", 32'(grant_id), 32'(0));
        check("por_data",  32'(data_in),  32'(0));
        tick();
        tick();
        rst = 1'b1;

        // Reset asserted mid-LOAD with every requester pending.
        hold_all  = 1'b1;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        wait_accept(id, at);
        check("pre_rst_grant", 32'(id), 32'(0));
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("async_start", 32'(start),     32'(0));
        check("async_busy",  32'(busy),      32'(0));
        check("async_ready", 32'(req_ready), 32'(0));
        check("async_data",  32'(data_in),   32'(0));
        tick();
        tick();
        rst = 1'b1;

        // Round-robin with all requesters continuously valid.
        prev_at = 0;
        for (int n = 0; n < 5; n++) begin
            wait_accept(id, at);
            check("rr_order", 32'(id), 32'(exp_order[n]));
            if (n > 0) check("rr_spacing", 32'(at - prev_at), 32'(SPACING));
            prev_at = at;
        end
        hold_all  = 1'b0;
        req_valid = '0;
        wait_idle();

        // Single requester 2 with 0xA5.
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        wait_accept(id, at);
        check("single_grant", 32'(id), 32'(2));
        check("single_data",  32'(data_in), 32'(8'hA5));
        n_start = 0;
        n_busy  = 0;
        for (int k = 0; k < TOTAL + 10; k++) begin
            tick();
            n_start += int'(seen_start);
            n_busy  += int'(seen_busy);
        end
        check("single_start_len", 32'(n_start), 32'(HOLD));
        check("single_busy_len",  32'(n_busy),  32'(TOTAL));
        check("single_no_ready",  32'(req_valid), 32'(0));

        // Late request from 1 and a withdrawn request from 3 during requester 0's frame.
        req_data[7:0] = 8'h5A;
        req_valid     = 4'b0001;
        wait_accept(id, at);
        check("late_first", 32'(id), 32'(0));
        prev_at = at;
        n_acc   = 0;
        tick();
        req_data[15:8] = 8'hC3;
        req_valid[1]   = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        req_valid[3] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        req_valid[3] = 1'b0;
        check("late_no_early_accept", 32'(n_acc), 32'(0));
        check("late_data_held", 32'(data_in), 32'(8'h5A));
        wait_accept(id, at);
        check("late_grant",   32'(id),           32'(1));
        check("late_spacing", 32'(at - prev_at), 32'(SPACING));
        check("late_data",    32'(data_in),      32'(8'hC3));
        wait_idle();
        for (int k = 0; k < 5; k++) tick();

        // Random traffic including withdrawals; the model checks every cycle.
        for (int k = 0; k < 2500; k++) begin
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i]       = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 99) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
